// File: rtl/tmds_pkg.sv
// Shared types, constants and helpers for the TMDS channel encoder.
// Holds the control tokens, the base pipeline latency and a popcount helper.
package tmds_pkg;

    // Latency without the optional input register stage.
    localparam int unsigned TMDS_LATENCY_BASE = 2;

    // Control tokens, indexed by {c1, c0}; bit 0 goes out first.
    localparam logic [9:0] TMDS_TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] TMDS_TOKEN_01 = 10'b0010101011;
    localparam logic [9:0] TMDS_TOKEN_10 = 10'b0101010100;
    localparam logic [9:0] TMDS_TOKEN_11 = 10'b1010101011;

    // Raw lane inputs as sampled from the pixel pipeline.
    typedef struct packed {
        logic       de;
        logic       c1;
        logic       c0;
        logic [7:0] d;
    } tmds_in_t;

    // Stage-1 result: transition-minimised word plus its sidebands.
    typedef struct packed {
        logic       de;
        logic       c1;
        logic       c0;
        logic [8:0] qm;
    } tmds_qm_t;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    function automatic logic [9:0] ctrl_token(input logic [1:0] c);
        logic [9:0] t;
        t = TMDS_TOKEN_00;
        unique case (c)
            2'b00: t = TMDS_TOKEN_00;
            2'b01: t = TMDS_TOKEN_01;
            2'b10: t = TMDS_TOKEN_10;
            2'b11: t = TMDS_TOKEN_11;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/tmds_qm.sv
// TMDS stage 1: XOR/XNOR transition-minimising chain plus its register.
// Ports: clk_pix, rst (sync, active-high), in_i (de/c1/c0/d), qm_o (registered).
module tmds_qm
    import tmds_pkg::*;
(
    input  logic     clk_pix,
    input  logic     rst,
    input  tmds_in_t in_i,
    output tmds_qm_t qm_o
);

    logic [3:0] n1d;
    logic       use_xnor;
    logic       bit_q;
    logic [8:0] qm_w;
    tmds_qm_t   s1_d;
    tmds_qm_t   s1_q;

    always_comb begin
        n1d      = popcount8(in_i.d);
        // XNOR chain yields fewer transitions for ones-heavy words;
        // the d[0] tie-break keeps the choice deterministic at n1d == 4.
        use_xnor = (n1d > 4'd4) ||
                   ((n1d == 4'd4) && !in_i.d[0]);
        qm_w     = '0;
        bit_q    = in_i.d[0];
        qm_w[0]  = bit_q;
        for (int i = 1; i < 8; i++) begin
            if (use_xnor) begin
                bit_q = ~(bit_q ^ in_i.d[i]);
            end else begin
                bit_q = bit_q ^ in_i.d[i];
            end
            qm_w[i] = bit_q;
        end
        qm_w[8]  = ~use_xnor;
    end

    always_comb begin
        s1_d    = '0;
        s1_d.de = in_i.de;
        s1_d.c1 = in_i.c1;
        s1_d.c0 = in_i.c0;
        s1_d.qm = qm_w;
    end

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            s1_q <= '0;
        end else begin
            s1_q <= s1_d;
        end
    end

    assign qm_o = s1_q;

endmodule

// File: rtl/tmds_encoder.sv
// One DVI lane TMDS encoder: 8-bit pixel + 2 control bits -> 10-bit symbol.
// Ports: clk_pix, rst, de_i, c0_i, c1_i, d_i -> q_o, de_o, disp_o (signed).
module tmds_encoder
    import tmds_pkg::*;
#(
    parameter int unsigned REG_INPUT = 0
) (
    input  logic              clk_pix,
    input  logic              rst,
    input  logic              de_i,
    input  logic              c0_i,
    input  logic              c1_i,
    input  logic [7:0]        d_i,
    output logic [9:0]        q_o,
    output logic              de_o,
    output logic signed [4:0] disp_o
);

    tmds_in_t in_w;
    tmds_in_t s0;
    tmds_qm_t s1;

    always_comb begin
        in_w    = '0;
        in_w.de = de_i;
        in_w.c1 = c1_i;
        in_w.c0 = c0_i;
        in_w.d  = d_i;
    end

    if (REG_INPUT != 0) begin : g_in_reg
        tmds_in_t in_q;

        always_ff @(posedge clk_pix) begin
            if (rst) begin
                in_q <= '0;
            end else begin
                in_q <= in_w;
            end
        end

        assign s0 = in_q;
    end else begin : g_in_comb
        assign s0 = in_w;
    end

    tmds_qm u_qm (
        .clk_pix (clk_pix),
        .rst     (rst),
        .in_i    (s0),
        .qm_o    (s1)
    );

    logic [3:0]        n1;
    logic [7:0]        qm;
    logic              m8;
    logic signed [4:0] bal;
    logic signed [4:0] adj_hi;
    logic signed [4:0] adj_lo;

    logic [9:0]        q_d;
    logic [9:0]        q_q;
    logic              de_d;
    logic              de_q;
    logic signed [4:0] cnt_d;
    logic signed [4:0] cnt_q;

    always_comb begin
        qm     = s1.qm[7:0];
        m8     = s1.qm[8];
        n1     = popcount8(qm);
        // n1 - n0 == 2*n1 - 8; the 5-bit wrap is exact over -8..+8.
        bal    = 5'({n1, 1'b0} - 5'd8);
        adj_hi = m8 ? 5'sd2 : 5'sd0;
        adj_lo = m8 ? 5'sd0 : 5'sd2;
    end

    always_comb begin
        q_d   = TMDS_TOKEN_00;
        cnt_d = '0;
        de_d  = s1.de;
        if (!s1.de) begin
            q_d   = ctrl_token({s1.c1, s1.c0});
            cnt_d = '0;
        end else if ((cnt_q == 5'sd0) ||
                     (n1 == 4'd4)) begin
            q_d = {~m8, m8, m8 ? qm : ~qm};
            if (m8) begin
                cnt_d = cnt_q + bal;
            end else begin
                cnt_d = cnt_q - bal;
            end
        end else if ((!cnt_q[4] && (n1 > 4'd4)) ||
                     (cnt_q[4] && (n1 < 4'd4))) begin
            // Invert to pull the running disparity back toward zero.
            q_d   = {1'b1, m8, ~qm};
            cnt_d = cnt_q + adj_hi - bal;
        end else begin
            q_d   = {1'b0, m8, qm};
            cnt_d = cnt_q - adj_lo + bal;
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            q_q   <= TMDS_TOKEN_00;
            de_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            q_q   <= q_d;
            de_q  <= de_d;
            cnt_q <= cnt_d;
        end
    end

    assign q_o    = q_q;
    assign de_o   = de_q;
    assign disp_o = cnt_q;

endmodule

// File: tb/tb_tmds_encoder.sv
// Bench for tmds_encoder: directed and random-line stimulus.
// Expected symbols are queued per cycle and checked by a negedge monitor.
module tb_tmds_encoder;
    import tmds_pkg::*;

    localparam int LAT = TMDS_LATENCY_BASE;

    logic              clk_pix = 1'b0;
    logic              rst     = 1'b1;
    logic              de_i    = 1'b0;
    logic              c0_i    = 1'b0;
    logic              c1_i    = 1'b0;
    logic [7:0]        d_i     = 8'h00;
    logic [9:0]        q_o;
    logic              de_o;
    logic signed [4:0] disp_o;

    tmds_encoder #(.REG_INPUT(0)) dut (
        .clk_pix (clk_pix),
        .rst     (rst),
        .de_i    (de_i),
        .c0_i    (c0_i),
        .c1_i    (c1_i),
        .d_i     (d_i),
        .q_o     (q_o),
        .de_o    (de_o),
        .disp_o  (disp_o)
    );

    always #5 clk_pix = ~clk_pix;

    int unsigned cyc = 0;
    always @(posedge clk_pix) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] cyc;
        logic [9:0]  q;
        logic        de;
        logic [4:0]  disp;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    mcnt  = 0;

    // Reference encoder; mcnt is the model's running disparity.
    function automatic logic [9:0] ref_enc(input logic de,
                                           input logic [1:0] c,
                                           input logic [7:0] d);
        int         ones;
        int         n1;
        int         n0;
        logic       x;
        logic [8:0] m;
        logic [9:0] q;
        if (!de) begin
            mcnt = 0;
            case (c)
                2'b00:   q = 10'h354;
                2'b01:   q = 10'h0AB;
                2'b10:   q = 10'h154;
                default: q = 10'h2AB;
            endcase
            return q;
        end
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        x = (ones > 4) || (ones == 4 && d[0] == 1'b0);
        m[0] = d[0];
        for (int i = 1; i < 8; i++)
            m[i] = x ? ~(m[i-1] ^ d[i]) : (m[i-1] ^ d[i]);
        m[8] = ~x;
        n1 = 0;
        for (int i = 0; i < 8; i++) n1 += int'(m[i]);
        n0 = 8 - n1;
        if (mcnt == 0 || n1 == n0) begin
            q = {~m[8], m[8], m[8] ? m[7:0] : ~m[7:0]};
            mcnt += m[8] ? (n1 - n0) : (n0 - n1);
        end else if ((mcnt > 0 && n1 > n0) || (mcnt < 0 && n0 > n1)) begin
            q = {1'b1, m[8], ~m[7:0]};
            mcnt += (m[8] ? 2 : 0) + (n0 - n1);
        end else begin
            q = {1'b0, m[8], m[7:0]};
            mcnt += (m[8] ? 0 : -2) + (n1 - n0);
        end
        return q;
    endfunction

    // One input cycle; queues the symbol expected LAT cycles later.
    task automatic apply(input logic r, input logic de,
                         input logic [1:0] c, input logic [7:0] d,
                         input string nm, input logic dir = 1'b0,
                         input logic [9:0] xq = 10'h000, input int xd = 0);
        exp_t e;
        int   n;
        @(posedge clk_pix);
        #1;
        rst  = r;
        de_i = de;
        c1_i = c[1];
        c0_i = c[0];
        d_i  = d;
        n    = int'(cyc);
        e    = '0;
        e.cyc = 32'(n + LAT);
        if (r) begin
            mcnt   = 0;
            e.q    = 10'h354;
            e.de   = 1'b0;
            e.disp = 5'd0;
            // The symbol already in flight is discarded by the reset.
            if (exp_q.size() > 0 &&
                exp_q[exp_q.size()-1].cyc == 32'(n + LAT - 1)) begin
                exp_q[exp_q.size()-1].q    = 10'h354;
                exp_q[exp_q.size()-1].de   = 1'b0;
                exp_q[exp_q.size()-1].disp = 5'd0;
                name_q[name_q.size()-1]    = nm;
            end
        end else if (dir) begin
            e.q    = xq;
            e.de   = de;
            e.disp = xd[4:0];
            mcnt   = de ? xd : 0;
        end else begin
            e.q    = ref_enc(de, c, d);
            e.de   = de;
            e.disp = mcnt[4:0];
        end
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    always @(negedge clk_pix) begin
        exp_t  e;
        string nm;
        while (exp_q.size() > 0 && exp_q[0].cyc < 32'(cyc)) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL %s: symbol for cycle %0d never checked", nm, e.cyc);
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == 32'(cyc)) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_vec++;
            if (q_o !== e.q || de_o !== e.de || disp_o !== $signed(e.disp)) begin
                n_err++;
                $display("FAIL %s @%0d: got q=%h de=%b disp=%0d, want q=%h de=%b disp=%0d",
                         nm, cyc, q_o, de_o, disp_o, e.q, e.de, $signed(e.disp));
            end
            n_vec++;
            if (!(disp_o <= 5'sd10 && disp_o >= -5'sd10)) begin
                n_err++;
                $display("FAIL disp_range %s @%0d: got disp=%0d, want |disp|<=10",
                         nm, cyc, disp_o);
            end
        end
    end

    initial begin
        logic [7:0] rd;

        repeat (3) apply(1'b1, 1'b1, 2'b00, 8'hAA, "reset");
        apply(1'b0, 1'b1, 2'b00, 8'hAA, "post_reset");
        apply(1'b0, 1'b0, 2'b00, 8'h00, "idle");

        apply(1'b0, 1'b0, 2'b00, 8'h00, "tok00", 1'b1, 10'h354, 0);
        apply(1'b0, 1'b0, 2'b01, 8'h00, "tok01", 1'b1, 10'h0AB, 0);
        apply(1'b0, 1'b0, 2'b10, 8'h00, "tok10", 1'b1, 10'h154, 0);
        apply(1'b0, 1'b0, 2'b11, 8'h00, "tok11", 1'b1, 10'h2AB, 0);

        apply(1'b0, 1'b1, 2'b00, 8'h00, "bal0", 1'b1, 10'h100, -8);
        apply(1'b0, 1'b1, 2'b00, 8'h00, "bal1", 1'b1, 10'h3FF, 2);
        apply(1'b0, 1'b0, 2'b00, 8'h00, "bal_end", 1'b1, 10'h354, 0);

        apply(1'b0, 1'b1, 2'b00, 8'hFF, "xnor_ff", 1'b1, 10'h200, -8);
        apply(1'b0, 1'b0, 2'b01, 8'h00, "ff_end", 1'b1, 10'h0AB, 0);

        for (int i = 0; i < 640; i++) begin
            rd = 8'($urandom_range(0, 255));
            apply(1'b0, 1'b1, 2'b00, rd, "line");
        end
        apply(1'b0, 1'b0, 2'b00, 8'h00, "line_tok", 1'b1, 10'h354, 0);
        apply(1'b0, 1'b0, 2'b10, 8'h00, "blank");
        apply(1'b0, 1'b0, 2'b11, 8'h00, "blank");

        apply(1'b0, 1'b1, 2'b00, 8'h00, "pre_rst");
        apply(1'b0, 1'b1, 2'b00, 8'h12, "pre_rst");
        apply(1'b1, 1'b1, 2'b00, 8'h34, "mid_rst");
        apply(1'b0, 1'b1, 2'b00, 8'h00, "post_rst0", 1'b1, 10'h100, -8);
        apply(1'b0, 1'b1, 2'b00, 8'h00, "post_rst1", 1'b1, 10'h3FF, 2);

        repeat (LAT + 1) apply(1'b0, 1'b0, 2'b00, 8'h00, "flush");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk_pix);
        #1;
        if (exp_q.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d symbols still queued, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
